// File: rtl/elev_pkg.sv
// Shared elevator constants: floor count, car FSM states and direction codes.
package elev_pkg;

    localparam int FLOORS  = 4;
    localparam int FLOOR_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } carStateT;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/floor_request_queue.sv
// Ordered floor-call queue: push-front/push-back, duplicate filter, pop-before-push.
module floor_request_queue
    import elev_pkg::*;
#(
    parameter int DEPTH = FLOORS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pushValid,
    input  logic [FLOOR_W-1:0]           pushFloor,
    input  logic                         pushFront,
    input  logic                         pop,
    output logic [FLOOR_W-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         pushAccepted
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [FLOOR_W-1:0] entries     [DEPTH];
    logic [FLOOR_W-1:0] afterPop    [DEPTH];
    logic [FLOOR_W-1:0] nextEntries [DEPTH];
    logic [CW-1:0]      popCount;
    logic [CW-1:0]      nextCount;
    logic               dup;
    logic               pushOk;

    assign head = entries[0];

    // Next queue contents: the pop is applied first, then the push is filtered against what remains.
    always_comb begin
        afterPop = entries;
        popCount = count;
        if (pop && (count != '0)) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                afterPop[i] = entries[i+1];
            end
            afterPop[DEPTH-1] = '0;
            popCount = count - 1'b1;
        end

        dup = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((32'(popCount) > i) && (afterPop[i] == pushFloor)) begin
                dup = 1'b1;
            end
        end
        pushOk = pushValid && !dup && (popCount != FULL_COUNT);

        nextEntries = afterPop;
        nextCount   = popCount;
        if (pushOk) begin
            if (pushFront) begin
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    nextEntries[i] = afterPop[i-1];
                end
                nextEntries[0] = pushFloor;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (32'(popCount) == i) begin
                        nextEntries[i] = pushFloor;
                    end
                end
            end
            nextCount = popCount + 1'b1;
        end
    end

    // Queue storage, occupancy flags and the push acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            pushAccepted <= 1'b0;
        end else begin
            entries      <= nextEntries;
            count        <= nextCount;
            empty        <= (nextCount == '0);
            full         <= (nextCount == FULL_COUNT);
            pushAccepted <= pushOk;
        end
    end

endmodule

// File: rtl/floor_call_dispatcher.sv
// Car dispatcher: serves the queue head, times floor travel and door dwell, pops served calls.
module floor_call_dispatcher
    import elev_pkg::*;
#(
    parameter int DEPTH         = FLOORS,
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               req_front,
    output logic               req_accept,
    output logic [FLOOR_W-1:0] pos0Mem,
    output logic [FLOOR_W-1:0] actualFloor,
    output logic               down_up_Flag,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door_open,
    output logic               queue_empty,
    output logic               queue_full
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

    carStateT                   state, stateNext;
    logic [TW-1:0]              travelCnt, travelNext;
    logic [DW-1:0]              doorCnt, doorNext;
    logic [FLOOR_W-1:0]         floorNext, stepFloor;
    logic                       dirNext;
    logic                       evalHead;
    logic                       pop;
    logic                       hasCall;
    logic [$clog2(DEPTH+1)-1:0] qCount;

    floor_request_queue #(
        .DEPTH(DEPTH)
    ) uQueue (
        .clk          (clk),
        .reset        (reset),
        .pushValid    (req_valid),
        .pushFloor    (req_floor),
        .pushFront    (req_front),
        .pop          (pop),
        .head         (pos0Mem),
        .count        (qCount),
        .empty        (queue_empty),
        .full         (queue_full),
        .pushAccepted (req_accept)
    );

    assign hasCall = (qCount != '0);

    // Next state: head is re-evaluated in IDLE and at every floor step, using the floor being entered.
    always_comb begin
        stateNext  = state;
        travelNext = travelCnt;
        doorNext   = doorCnt;
        floorNext  = actualFloor;
        dirNext    = down_up_Flag;
        evalHead   = 1'b0;
        pop        = 1'b0;
        stepFloor  = (state == MOVE_DOWN) ? actualFloor - 1'b1 : actualFloor + 1'b1;

        unique case (state)
            IDLE: begin
                evalHead = hasCall;
            end
            MOVE_UP, MOVE_DOWN: begin
                if (travelCnt == TRAVEL_LAST) begin
                    travelNext = '0;
                    floorNext  = stepFloor;
                    evalHead   = 1'b1;
                end else begin
                    travelNext = travelCnt + 1'b1;
                end
            end
            DOOR: begin
                if (doorCnt == DOOR_LAST) begin
                    doorNext  = '0;
                    stateNext = IDLE;
                end else begin
                    doorNext = doorCnt + 1'b1;
                end
            end
        endcase

        if (evalHead) begin
            if (!hasCall) begin
                stateNext = IDLE;
            end else if (pos0Mem == floorNext) begin
                pop       = 1'b1;
                stateNext = DOOR;
            end else if (pos0Mem > floorNext) begin
                stateNext = MOVE_UP;
                dirNext   = DIR_UP;
            end else begin
                stateNext = MOVE_DOWN;
                dirNext   = DIR_DOWN;
            end
        end
    end

    // State, counters, position and registered car controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            travelCnt    <= '0;
            doorCnt      <= '0;
            actualFloor  <= '0;
            down_up_Flag <= DIR_UP;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            door_open    <= 1'b0;
        end else begin
            state        <= stateNext;
            travelCnt    <= travelNext;
            doorCnt      <= doorNext;
            actualFloor  <= floorNext;
            down_up_Flag <= dirNext;
            motor_up     <= (stateNext == MOVE_UP);
            motor_down   <= (stateNext == MOVE_DOWN);
            door_open    <= (stateNext == DOOR);
        end
    end

endmodule
